pc_sequencer: RTL and testbench

Parametrised program-counter unit for the CPU datapath. It holds the PC register and computes the next PC for sequential, jump, conditional-branch, call and return flow. A DEPTH-entry return-address stack handles call/return. The block stalls cleanly on memory busywait and sits between the control unit (op, offset, ALU zero flag) and the instruction memory address port.

---
 rtl/pc_sequencer.sv | 183 ++++++++++++++++++
 tb/tb_pc_sequencer.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// pc_sequencer
//
// Program-counter unit for the CPU datapath. Holds the PC register and
// selects the next PC for sequential, jump, conditional-branch, call and
// return flow. Calls and returns go through a DEPTH-entry circular
// return-address stack (RAS). While BUSYWAIT is high, nothing architectural
// changes, so the pending op executes exactly once when the stall ends.
//
// Ports:
//   CLK        in   rising-edge clock
//   RESET      in   asynchronous active-low reset
//   BUSYWAIT   in   memory stall; holds all state while high
//   PC_OP      in   3-bit op: 000 seq, 001 jump, 010 beq, 011 bne,
//                   100 call, 101 ret, 110/111 behave as seq
//   ZERO       in   ALU zero flag for beq/bne
//   OFFSET     in   signed instruction offset (OFFSET_WIDTH bits)
//   PC         out  current PC (registered)
//   PC_PLUS    out  PC + STEP (combinational)
//   TAKEN      out  next PC comes from somewhere other than PC_PLUS
//   RAS_EMPTY  out  stack holds no entries
//   RAS_FULL   out  stack holds DEPTH entries
//   RAS_OVF    out  sticky: call issued while the stack was full
//   RAS_UNF    out  sticky: ret issued while the stack was empty

module pc_sequencer #(
  parameter int unsigned         PC_WIDTH     = 32,
  parameter int unsigned         OFFSET_WIDTH = 8,
  parameter int unsigned         STEP         = 4,
  parameter int unsigned         OFFSET_SHIFT = 2,
  parameter logic [PC_WIDTH-1:0] RESET_VECTOR = '0,
  parameter int unsigned         DEPTH        = 4
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic                    BUSYWAIT,
  input  logic [2:0]              PC_OP,
  input  logic                    ZERO,
  input  logic [OFFSET_WIDTH-1:0] OFFSET,
  output logic [PC_WIDTH-1:0]     PC,
  output logic [PC_WIDTH-1:0]     PC_PLUS,
  output logic                    TAKEN,
  output logic                    RAS_EMPTY,
  output logic                    RAS_FULL,
  output logic                    RAS_OVF,
  output logic                    RAS_UNF
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  localparam logic [2:0] OP_JUMP = 3'b001;
  localparam logic [2:0] OP_BEQ  = 3'b010;
  localparam logic [2:0] OP_BNE  = 3'b011;
  localparam logic [2:0] OP_CALL = 3'b100;
  localparam logic [2:0] OP_RET  = 3'b101;

  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                ovf_q, ovf_d;
  logic                unf_q, unf_d;
  logic [PC_WIDTH-1:0] ras_q [DEPTH];
  logic [PC_WIDTH-1:0] ras_d [DEPTH];

  logic [PC_WIDTH-1:0] pc_plus;
  logic [PC_WIDTH-1:0] off_sext;
  logic [PC_WIDTH-1:0] target;
  logic [PC_WIDTH-1:0] ras_top;
  logic [PTR_W-1:0]    top_ptr;
  logic                ras_empty;
  logic                ras_full;
  logic [PC_WIDTH-1:0] next_pc;
  logic                taken;

  // Sizing a signed value sign-extends it; all sums wrap modulo 2^PC_WIDTH.
  assign pc_plus  = pc_q + PC_WIDTH'(STEP);
  assign off_sext = PC_WIDTH'($signed(OFFSET));
  assign target   = pc_plus + (off_sext << OFFSET_SHIFT);

  // The write pointer always points one past the newest entry, so the
  // top of stack sits just below it (wrapping around the ring).
  assign top_ptr   = wr_ptr_q - PTR_W'(1);
  assign ras_top   = ras_q[top_ptr];
  assign ras_empty = (count_q == '0);
  assign ras_full  = (count_q == CNT_W'(DEPTH));

  // Next-PC selection and stack bookkeeping. The stack and flag updates are
  // only committed when not stalled; TAKEN reflects the op regardless.
  always_comb begin
    next_pc  = pc_plus;
    taken    = 1'b0;
    pc_d     = pc_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;
    ras_d    = ras_q;

    case (PC_OP)
      OP_JUMP: begin
        next_pc = target;
        taken   = 1'b1;
      end
      OP_BEQ: begin
        if (ZERO) begin
          next_pc = target;
          taken   = 1'b1;
        end
      end
      OP_BNE: begin
        if (!ZERO) begin
          next_pc = target;
          taken   = 1'b1;
        end
      end
      OP_CALL: begin
        next_pc = target;
        taken   = 1'b1;
      end
      OP_RET: begin
        if (!ras_empty) begin
          next_pc = ras_top;
          taken   = 1'b1;
        end
      end
      default: begin
        next_pc = pc_plus;
        taken   = 1'b0;
      end
    endcase

    if (!BUSYWAIT) begin
      pc_d = next_pc;
      if (PC_OP == OP_CALL) begin
        // When full, the write pointer lands on the oldest entry, so the
        // push naturally overwrites it and the newest DEPTH stay LIFO.
        ras_d[wr_ptr_q] = pc_plus;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        if (ras_full) begin
          ovf_d = 1'b1;
        end else begin
          count_d = count_q + CNT_W'(1);
        end
      end else if (PC_OP == OP_RET) begin
        if (ras_empty) begin
          unf_d = 1'b1;
        end else begin
          wr_ptr_d = top_ptr;
          count_d  = count_q - CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      pc_q     <= RESET_VECTOR;
      wr_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        ras_q[i] <= '0;
      end
    end else begin
      pc_q     <= pc_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
      ras_q    <= ras_d;
    end
  end

  assign PC        = pc_q;
  assign PC_PLUS   = pc_plus;
  assign TAKEN     = taken;
  assign RAS_EMPTY = ras_empty;
  assign RAS_FULL  = ras_full;
  assign RAS_OVF   = ovf_q;
  assign RAS_UNF   = unf_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer
//
// Directed bench for pc_sequencer. Instance "a" uses default parameters
// (32-bit PC, DEPTH 4); instance "b" uses an 8-bit PC with reset vector
// 0xFC to exercise address wrap and reset during a stall.

module tb_pc_sequencer;

  localparam logic [2:0] OP_SEQ  = 3'b000;
  localparam logic [2:0] OP_JUMP = 3'b001;
  localparam logic [2:0] OP_BEQ  = 3'b010;
  localparam logic [2:0] OP_BNE  = 3'b011;
  localparam logic [2:0] OP_CALL = 3'b100;
  localparam logic [2:0] OP_RET  = 3'b101;

  logic clk = 1'b0;

  // 10-time-unit clock; rising edges at 5, 15, 25, ...
  always #5 clk = ~clk;

  logic        reset_a, busy_a, zero_a;
  logic [2:0]  op_a;
  logic [7:0]  off_a;
  logic [31:0] pc_a, pc_plus_a;
  logic        taken_a, empty_a, full_a, ovf_a, unf_a;

  logic        reset_b, busy_b, zero_b;
  logic [2:0]  op_b;
  logic [7:0]  off_b;
  logic [7:0]  pc_b, pc_plus_b;
  logic        taken_b, empty_b, full_b, ovf_b, unf_b;

  int check_count = 0;
  int error_count = 0;

  pc_sequencer dut_a (
    .CLK       (clk),
    .RESET     (reset_a),
    .BUSYWAIT  (busy_a),
    .PC_OP     (op_a),
    .ZERO      (zero_a),
    .OFFSET    (off_a),
    .PC        (pc_a),
    .PC_PLUS   (pc_plus_a),
    .TAKEN     (taken_a),
    .RAS_EMPTY (empty_a),
    .RAS_FULL  (full_a),
    .RAS_OVF   (ovf_a),
    .RAS_UNF   (unf_a)
  );

  pc_sequencer #(
    .PC_WIDTH     (8),
    .RESET_VECTOR (8'hFC)
  ) dut_b (
    .CLK       (clk),
    .RESET     (reset_b),
    .BUSYWAIT  (busy_b),
    .PC_OP     (op_b),
    .ZERO      (zero_b),
    .OFFSET    (off_b),
    .PC        (pc_b),
    .PC_PLUS   (pc_plus_b),
    .TAKEN     (taken_b),
    .RAS_EMPTY (empty_b),
    .RAS_FULL  (full_b),
    .RAS_OVF   (ovf_b),
    .RAS_UNF   (unf_b)
  );

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    check_count++;
    if (got !== exp) begin
      error_count++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // Drives one instance's control inputs and lets combinational outputs settle.
  task automatic applyStimulus(input bit sel_b, input logic [2:0] op, input logic zero,
                               input logic [7:0] off, input logic busy);
    if (!sel_b) begin
      op_a = op; zero_a = zero; off_a = off; busy_a = busy;
    end else begin
      op_b = op; zero_b = zero; off_b = off; busy_b = busy;
    end
    #1;
  endtask

  // Advances one rising edge and samples 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkFlagsA(input string tag, input logic empty, input logic full,
                             input logic ovf, input logic unf);
    checkOutput({tag, ".empty"}, 32'(empty_a), 32'(empty));
    checkOutput({tag, ".full"},  32'(full_a),  32'(full));
    checkOutput({tag, ".ovf"},   32'(ovf_a),   32'(ovf));
    checkOutput({tag, ".unf"},   32'(unf_a),   32'(unf));
  endtask

  // Pulses instance a's reset away from any clock edge.
  task automatic resetA();
    reset_a = 1'b0;
    #1;
    reset_a = 1'b1;
    #1;
  endtask

  initial begin
    reset_a = 1'b0; busy_a = 1'b0; zero_a = 1'b0; op_a = OP_SEQ; off_a = '0;
    reset_b = 1'b0; busy_b = 1'b0; zero_b = 1'b0; op_b = OP_SEQ; off_b = '0;

    // Reset state while reset is held
    #12;
    checkOutput("rst.pc", pc_a, 32'h0);
    checkOutput("rst.pc_plus", pc_plus_a, 32'h4);
    checkFlagsA("rst", 1'b1, 1'b0, 1'b0, 1'b0);
    reset_a = 1'b1;

    // Sequential flow
    applyStimulus(0, OP_SEQ, 1'b0, 8'h00, 1'b0);
    checkOutput("seq.taken", 32'(taken_a), 32'd0);
    tick(); checkOutput("seq1.pc", pc_a, 32'h04);
    tick(); checkOutput("seq2.pc", pc_a, 32'h08);
    tick(); checkOutput("seq3.pc", pc_a, 32'h0C);
    checkOutput("seq3.pc_plus", pc_plus_a, 32'h10);
    applyStimulus(0, 3'b111, 1'b0, 8'h7F, 1'b0);
    checkOutput("rsvd.taken", 32'(taken_a), 32'd0);
    tick(); checkOutput("rsvd.pc", pc_a, 32'h10);
    checkFlagsA("seq", 1'b1, 1'b0, 1'b0, 1'b0);

    // Branches from 0x10: 0x14 + (-2 << 2) = 0x0C
    applyStimulus(0, OP_BEQ, 1'b1, 8'hFE, 1'b0);
    checkOutput("beq_t.taken", 32'(taken_a), 32'd1);
    tick(); checkOutput("beq_t.pc", pc_a, 32'h0C);
    applyStimulus(0, OP_JUMP, 1'b0, 8'h00, 1'b0);
    checkOutput("jmp0.taken", 32'(taken_a), 32'd1);
    tick(); checkOutput("jmp0.pc", pc_a, 32'h10);
    applyStimulus(0, OP_BEQ, 1'b0, 8'hFE, 1'b0);
    checkOutput("beq_nt.taken", 32'(taken_a), 32'd0);
    tick(); checkOutput("beq_nt.pc", pc_a, 32'h14);
    applyStimulus(0, OP_BNE, 1'b1, 8'h03, 1'b0);
    checkOutput("bne_nt.taken", 32'(taken_a), 32'd0);
    tick(); checkOutput("bne_nt.pc", pc_a, 32'h18);
    // 0x1C + (3 << 2) = 0x28
    applyStimulus(0, OP_BNE, 1'b0, 8'h03, 1'b0);
    checkOutput("bne_t.taken", 32'(taken_a), 32'd1);
    tick(); checkOutput("bne_t.pc", pc_a, 32'h28);

    // Nested call/return from a fresh reset
    resetA();
    checkOutput("rst2.pc", pc_a, 32'h0);
    applyStimulus(0, OP_CALL, 1'b0, 8'h04, 1'b0);
    tick(); checkOutput("call1.pc", pc_a, 32'h14);
    checkOutput("call1.empty", 32'(empty_a), 32'd0);
    tick(); checkOutput("call2.pc", pc_a, 32'h28);
    applyStimulus(0, OP_RET, 1'b0, 8'h00, 1'b0);
    checkOutput("ret1.taken", 32'(taken_a), 32'd1);
    tick(); checkOutput("ret1.pc", pc_a, 32'h18);
    tick(); checkOutput("ret2.pc", pc_a, 32'h04);
    checkFlagsA("nest", 1'b1, 1'b0, 1'b0, 1'b0);

    // Overflow: calls with offset 1 go to PC+8 and push PC+4
    resetA();
    applyStimulus(0, OP_CALL, 1'b0, 8'h01, 1'b0);
    tick(); checkOutput("ovf_c1.pc", pc_a, 32'h08);
    tick(); checkOutput("ovf_c2.pc", pc_a, 32'h10);
    tick(); checkOutput("ovf_c3.pc", pc_a, 32'h18);
    tick(); checkOutput("ovf_c4.pc", pc_a, 32'h20);
    checkFlagsA("ovf_c4", 1'b0, 1'b1, 1'b0, 1'b0);
    tick(); checkOutput("ovf_c5.pc", pc_a, 32'h28);
    checkFlagsA("ovf_c5", 1'b0, 1'b1, 1'b1, 1'b0);

    // Returns pop 0x24, 0x1C, 0x14, 0x0C (0x04 was overwritten)
    applyStimulus(0, OP_RET, 1'b0, 8'h00, 1'b0);
    tick(); checkOutput("unf_r1.pc", pc_a, 32'h24);
    checkOutput("unf_r1.full", 32'(full_a), 32'd0);
    tick(); checkOutput("unf_r2.pc", pc_a, 32'h1C);
    tick(); checkOutput("unf_r3.pc", pc_a, 32'h14);
    tick(); checkOutput("unf_r4.pc", pc_a, 32'h0C);
    checkFlagsA("unf_r4", 1'b1, 1'b0, 1'b1, 1'b0);
    checkOutput("unf_r5.taken", 32'(taken_a), 32'd0);
    tick(); checkOutput("unf_r5.pc", pc_a, 32'h10);
    checkFlagsA("unf_r5", 1'b1, 1'b0, 1'b1, 1'b1);

    // Stall: call held for three edges, then executes exactly once
    applyStimulus(0, OP_CALL, 1'b0, 8'h01, 1'b1);
    checkOutput("stall.taken", 32'(taken_a), 32'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("stall.pc", pc_a, 32'h10);
      checkOutput("stall.empty", 32'(empty_a), 32'd1);
    end
    applyStimulus(0, OP_CALL, 1'b0, 8'h01, 1'b0);
    tick(); checkOutput("unstall.pc", pc_a, 32'h18);
    checkOutput("unstall.empty", 32'(empty_a), 32'd0);
    applyStimulus(0, OP_RET, 1'b0, 8'h00, 1'b0);
    tick(); checkOutput("unstall_ret.pc", pc_a, 32'h14);
    checkFlagsA("unstall_ret", 1'b1, 1'b0, 1'b1, 1'b1);
    applyStimulus(0, OP_SEQ, 1'b0, 8'h00, 1'b0);

    // 8-bit instance: wrap and jump with truncated offset
    checkOutput("b_rst.pc", 32'(pc_b), 32'hFC);
    checkOutput("b_rst.pc_plus", 32'(pc_plus_b), 32'h00);
    reset_b = 1'b1;
    applyStimulus(1, OP_SEQ, 1'b0, 8'h00, 1'b0);
    tick(); checkOutput("b_wrap.pc", 32'(pc_b), 32'h00);
    // 0x80 sign-extends and shifts to 0x200, truncated to 0x00
    applyStimulus(1, OP_JUMP, 1'b0, 8'h80, 1'b0);
    checkOutput("b_jmp.taken", 32'(taken_b), 32'd1);
    tick(); checkOutput("b_jmp.pc", 32'(pc_b), 32'h04);
    applyStimulus(1, OP_CALL, 1'b0, 8'h01, 1'b0);
    tick(); checkOutput("b_call.pc", 32'(pc_b), 32'h0C);
    checkOutput("b_call.empty", 32'(empty_b), 32'd0);

    // Reset during a stall returns to the reset state immediately
    applyStimulus(1, OP_CALL, 1'b0, 8'h01, 1'b1);
    tick(); checkOutput("b_stall.pc", 32'(pc_b), 32'h0C);
    reset_b = 1'b0;
    #1;
    checkOutput("b_midrst.pc", 32'(pc_b), 32'hFC);
    checkOutput("b_midrst.empty", 32'(empty_b), 32'd1);
    checkOutput("b_midrst.full", 32'(full_b), 32'd0);
    checkOutput("b_midrst.ovf", 32'(ovf_b), 32'd0);
    checkOutput("b_midrst.unf", 32'(unf_b), 32'd0);
    tick(); checkOutput("b_held.pc", 32'(pc_b), 32'hFC);

    $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
    $finish;
  end

endmodule
